tiling_engine: RTL
==================

# tiling_engine

Parametrised multi-channel column-to-tile assembler. Each of NUM_CH input channels (one per convolution core) streams columns of DATA_W bits into a private ping-pong pair of banks. A bank holding TILE_DEPTH columns is a complete tile. A round-robin arbiter presents complete tiles one at a time on a registered valid/ready output port. It sits between the overlapped-column outputs of the cores and the feature-map consumer, and adds true backpressure toward the cores.

## Interface
Parameters:
- DATA_W, 128, width of one column.
- NUM_CH, 4, number of input channels; range 2..8.
- TILE_DEPTH, 16, columns per tile; range 2..32.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- col_data_i  in  NUM_CH*DATA_W  channel c column at bits [c*DATA_W +: DATA_W].
- col_valid_i  in  NUM_CH  channel c column present.
- col_ready_o  out  NUM_CH  channel c can accept; high when the channel's write bank is free.
- tile_o  out  DATA_W*TILE_DEPTH  tile; column k at bits [k*DATA_W +: DATA_W], k=0 is first written.
- tile_valid_o  out  1  tile_o, tile_ch_o valid.
- tile_ready_i  in  1  consumer accepts.
- tile_ch_o  out  $clog2(NUM_CH)  source channel of the presented tile.
- overflow_o  out  NUM_CH  one-cycle pulse; column on channel c offered while col_ready_o[c]=0 and dropped.

## Operation
- Per channel state: wr_bank (1 bit), wr_cnt (0..TILE_DEPTH), full[1:0] per bank.
- Write accepted when col_valid_i[c] and col_ready_o[c]. The column is stored at wr_cnt in bank wr_bank, and wr_cnt increments.
- When the accept fills slot TILE_DEPTH-1, that bank's full flag is set, wr_cnt goes to 0, and wr_bank toggles.
- col_ready_o[c] = !full[wr_bank]. If both banks are full, the channel stalls.
- Output FSM states:
  - IDLE: search for a channel with an oldest full bank (rd_bank per channel). The search runs round-robin starting at last_grant+1 mod NUM_CH. On a hit, load tile_o, tile_ch_o, latch the grant, and go to PRESENT.
  - PRESENT: tile_valid_o=1. tile_o and tile_ch_o are held stable until tile_ready_i=1. On acceptance, clear full[rd_bank] of the granted channel, toggle its rd_bank, set last_grant, and go to IDLE.
- Grant on one tile per cycle pair. Back-to-back tiles have a 1-cycle IDLE gap, so peak throughput is one tile per 2 cycles.
- Reset values:
  - All banks empty; wr_cnt=0, wr_bank=rd_bank=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
  - tile_valid_o=0, tile_o=0, tile_ch_o=0, overflow_o=0.
  - col_ready_o is all ones after reset release.

## Timing
- A last column accepted at edge E sets full at E. The arbiter (if in IDLE) loads the output at E+1, so tile_valid_o is high from E+1. Latency is 1 cycle after tile completion.
- A bank freed at acceptance edge A makes col_ready_o rise from A. If the channel was stalled, its first new write can land at A+1.
- Simultaneous events:
  - If a write completes a bank in the same cycle the other bank of that channel is accepted, both take effect. The channel stays ready.
  - A completing bank is not eligible for arbitration in the cycle it completes.
- Wrap-around: wr_cnt and rd_bank wrap with no bubble. The round-robin pointer wraps at NUM_CH-1 to 0.
- overflow_o[c] is registered: it is high the cycle after the dropped offer.
- Reset asserted mid-operation discards all buffered tiles immediately (async). A tile in PRESENT is withdrawn: tile_valid_o falls without a handshake.

## Configuration
- TILING_ENGINE_FLUSH_EN defined: adds port flush_i in [NUM_CH].
  - A pulse on channel c with wr_cnt>0 closes the current bank. Remaining columns are zero-filled, and the bank is marked full at that edge.
  - A column accepted in the same cycle is stored before closing.
  - A flush with wr_cnt=0, or with a data-free partial write, is ignored.
- TILING_ENGINE_FLUSH_EN undefined: no flush_i port. Tiles are emitted only when TILE_DEPTH columns have been written.

## Test plan
- Single channel, defaults: 16 columns 0x1..0x10 on channel 0 with tile_ready_i=1.
  - Expect tile_valid_o 1 cycle after the 16th column, tile_ch_o=0, column k = k+1.
- Backpressure: channel 2 writes 32 columns with tile_ready_i=0.
  - Expect col_ready_o[2]=0 after the 32nd.
  - A 33rd offer gives overflow_o[2] pulse, data dropped.
  - After one accept, col_ready_o[2]=1.
- Fairness: all 4 channels complete tiles in the same cycle, tile_ready_i=1.
  - Expect grants in order 0,1,2,3, each 2 cycles apart.
- Hold: tile presented, tile_ready_i low for 5 cycles.
  - Expect tile_o and tile_ch_o constant and the second bank still filling.
- Reset mid-PRESENT: assert rst_i low while tile_valid_o=1.
  - Expect tile_valid_o=0, col_ready_o all ones after release, and no stale tile emitted.
- FLUSH_EN: 5 columns then flush_i[1].
  - Expect a tile on channel 1 with columns 0..4 = data and columns 5..15 = 0.

Source files
------------

// File: rtl/tiling_engine.sv
// Multi-channel column-to-tile assembler: per-channel ping-pong banks, round-robin tile output.
// Optional feature macro: TILING_ENGINE_FLUSH_EN (adds flush_i to close a partial bank with zero fill).
module tiling_engine #(
  parameter int DATA_W     = 128,
  parameter int NUM_CH     = 4,
  parameter int TILE_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH*DATA_W-1:0]     col_data_i,
  input  logic [NUM_CH-1:0]            col_valid_i,
  output logic [NUM_CH-1:0]            col_ready_o,
`ifdef TILING_ENGINE_FLUSH_EN
  input  logic [NUM_CH-1:0]            flush_i,
`endif
  output logic [DATA_W*TILE_DEPTH-1:0] tile_o,
  output logic                         tile_valid_o,
  input  logic                         tile_ready_i,
  output logic [$clog2(NUM_CH)-1:0]    tile_ch_o,
  output logic [NUM_CH-1:0]            overflow_o,
  output logic                         dbg_state_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TILE_DEPTH + 1);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  // Handshake: a column moves when col_valid_i[c] && col_ready_o[c] at a rising edge;
  // a tile moves when tile_valid_o && tile_ready_i, and tile_o/tile_ch_o stay stable until then.

  state_t                      state;
  logic [DATA_W-1:0]           mem [NUM_CH][2][TILE_DEPTH];
  logic [CNT_W-1:0]            wr_cnt     [NUM_CH];
  logic [CNT_W-1:0]            wr_cnt_nxt [NUM_CH];
  logic [1:0]                  full       [NUM_CH];
  logic [1:0]                  full_nxt   [NUM_CH];
  logic [NUM_CH-1:0]           wr_bank, wr_bank_nxt;
  logic [NUM_CH-1:0]           rd_bank, rd_bank_nxt;
  logic [NUM_CH-1:0]           acc;
  logic [NUM_CH-1:0]           bank_close;
  logic [NUM_CH-1:0]           flush_close;
  logic [NUM_CH-1:0]           elig;
  logic [NUM_CH-1:0]           rd_done;
  logic [CH_W-1:0]             last_grant;
  logic [CH_W-1:0]             sel;
  logic                        hit;
  logic [DATA_W*TILE_DEPTH-1:0] tile_sel;

  assign dbg_state_o = (state == S_PRESENT);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      col_ready_o[c] = !full[c][wr_bank[c]];
      acc[c]         = col_valid_i[c] && col_ready_o[c];
      elig[c]        = full[c][rd_bank[c]];
      rd_done[c]     = (state == S_PRESENT) && tile_ready_i && (tile_ch_o == CH_W'(c));
    end
  end

  // Per-channel next state: write completion/flush sets a bank full, a read handshake frees one.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full_nxt[c]    = full[c];
      wr_cnt_nxt[c]  = wr_cnt[c];
      wr_bank_nxt[c] = wr_bank[c];
      rd_bank_nxt[c] = rd_bank[c];
      bank_close[c]  = 1'b0;
      flush_close[c] = 1'b0;
      if (acc[c]) begin
        if (wr_cnt[c] == CNT_W'(TILE_DEPTH - 1)) bank_close[c] = 1'b1;
        else wr_cnt_nxt[c] = wr_cnt[c] + 1'b1;
      end
`ifdef TILING_ENGINE_FLUSH_EN
      if (flush_i[c] && (acc[c] || wr_cnt[c] != '0)) begin
        flush_close[c] = 1'b1;
        bank_close[c]  = 1'b1;
      end
`endif
      if (bank_close[c]) begin
        full_nxt[c][wr_bank[c]] = 1'b1;
        wr_cnt_nxt[c]           = '0;
        wr_bank_nxt[c]          = ~wr_bank[c];
      end
      if (rd_done[c]) begin
        full_nxt[c][rd_bank[c]] = 1'b0;
        rd_bank_nxt[c]          = ~rd_bank[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        full[c]   <= '0;
        wr_cnt[c] <= '0;
      end
      wr_bank <= '0;
      rd_bank <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        full[c]   <= full_nxt[c];
        wr_cnt[c] <= wr_cnt_nxt[c];
      end
      wr_bank <= wr_bank_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // Bank storage carries no reset; validity lives entirely in the full flags.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < TILE_DEPTH; k++) begin
        if (acc[c] && wr_cnt[c] == CNT_W'(k))
          mem[c][wr_bank[c]][k] <= col_data_i[c*DATA_W +: DATA_W];
        else if (flush_close[c] && wr_cnt[c] <= CNT_W'(k))
          mem[c][wr_bank[c]][k] <= '0;
      end
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    idx = 0;
    hit = 1'b0;
    sel = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        sel = CH_W'(idx);
      end
    end
  end

  always_comb begin
    tile_sel = '0;
    for (int k = 0; k < TILE_DEPTH; k++)
      tile_sel[k*DATA_W +: DATA_W] = mem[sel][rd_bank[sel]][k];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      tile_o       <= '0;
      tile_valid_o <= 1'b0;
      tile_ch_o    <= '0;
      last_grant   <= CH_W'(NUM_CH - 1);
      overflow_o   <= '0;
    end else begin
      overflow_o <= col_valid_i & ~col_ready_o;
      case (state)
        S_IDLE: begin
          if (hit) begin
            tile_o       <= tile_sel;
            tile_ch_o    <= sel;
            tile_valid_o <= 1'b1;
            state        <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (tile_ready_i) begin
            tile_valid_o <= 1'b0;
            last_grant   <= tile_ch_o;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
